serial_alu: RTL
===============

# serial_alu

Parametrised bit-serial add/subtract/accumulate unit for the board-lab datapath. It is the sequential successor to the combinational ripple-carry adder. One full-adder cell plus a carry flip-flop processes WIDTH-bit operands LSB-first, one bit per clock, under a Start/Busy/Done handshake. A result register holds the last value for HEX/LEDR display and for accumulate mode.

## Interface
- WIDTH, 8, operand/result width in bits; legal range ≥ 2.
- Clock  in  1  system clock, rising-edge active (CLOCK_50 at top level).
- Resetn  in  1  asynchronous, active-low reset.
- Start  in  1  request; sampled only in IDLE.
- Op  in  2  00 ADD, 01 SUB, 10 ACC, 11 CLR; sampled with Start.
- A  in  WIDTH  first operand (ADD/SUB); addend for ACC.
- B  in  WIDTH  second operand (ADD/SUB); ignored for ACC/CLR.
- Cin  in  1  carry-in for ADD and ACC; ignored for SUB/CLR.
- Busy  out  1  high while bits are being processed.
- Done  out  1  one-cycle completion pulse.
- Result  out  WIDTH  registered result of last completed op.
- Cout  out  1  carry out of MSB (SUB: 1 = no borrow).
- Overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE + Start=1 at edge k:
  - latch operands into shift registers X, Y and load bit counter = 0.
  - ADD: X=A, Y=B, carry=Cin.
  - SUB: X=A, Y=~B, carry=1.
  - ACC: X=Result (current value), Y=A, carry=Cin.
  - CLR: Result, Cout and Overflow are cleared to 0 at edge k; go directly to DONE; Busy is never asserted.
  - Other ops go to RUN.
- RUN: each edge computes sum/carry of X[0], Y[0], carry, then shifts the sum into the MSB of sum register S and shifts X and Y right. The counter increments. The carry entering bit WIDTH-1 is saved for Overflow.
- At the edge processing bit WIDTH-1:
  - Result ← final S.
  - Cout ← final carry.
  - Overflow ← saved carry XOR final carry.
  - state → DONE.
- DONE: Done=1 for one cycle, then IDLE unconditionally.
- Start in RUN or DONE is ignored (not queued). Op, A, B and Cin may change freely after edge k.
- Result, Cout and Overflow change only at completion; they are stable throughout RUN.
- Arithmetic is modulo 2^WIDTH; Result never holds partial sums.
- Reset (any state, asynchronous): state=IDLE; Result=0, Cout=0, Overflow=0, Busy=0, Done=0. Internal shift registers and counter are cleared. An in-flight operation is aborted with no Done pulse.

## Timing
- Busy = (state==RUN): high in cycles k+1 … k+WIDTH (exactly WIDTH cycles).
- Result/Cout/Overflow update at edge k+WIDTH. Done is high in the cycle after that edge, and is observed at edge k+WIDTH+1.
- CLR: Done is observed at edge k+1.
- Start is next accepted at edge k+WIDTH+2 (CLR: k+2). Minimum issue interval is WIDTH+2 cycles (CLR: 2).
- Busy and Done are never high together. Both are registered outputs with no combinational path from the inputs.
- Counter width is clog2(WIDTH); the terminal count is WIDTH-1.

## Test plan
- WIDTH=4, ADD A=7 B=9 Cin=0 → Busy high 4 cycles; Done pulse at k+5; Result=0, Cout=1, Overflow=0.
- WIDTH=4, SUB A=3 B=5 → Result=4'hE, Cout=0, Overflow=0. Then ADD A=7 B=1 Cin=0 → Result=8, Cout=0, Overflow=1.
- WIDTH=4, accumulate sequence:
  - CLR → Done at k+1, Result=0.
  - ACC A=5 three times → Result 5, 10, 15.
  - ACC A=1 → Result=0, Cout=1, Overflow=0.
- WIDTH=4, Start pulsed every cycle for 20 cycles with ADD A=1 B=1 Cin=1 → exactly one op per 6 cycles; each Result=3; no Done/Busy overlap.
- WIDTH=4, reset mid-op: after Result=15, start ADD A=2 B=2, drop Resetn at k+2 → outputs immediately 0, no Done. After release, ADD A=2 B=2 → Result=4.
- WIDTH=8, SUB A=8'h80 B=8'h01 → Result=8'h7F, Cout=1, Overflow=1. Done at k+9. Result holds 8'h80? No: Result holds the prior value until edge k+8.

Source files
------------

// File: rtl/serial_alu.sv
// ---------------------------------------------------------------------------
// serial_alu
//   Bit-serial add / subtract / accumulate unit. A single full-adder cell and
//   a carry flip-flop process WIDTH-bit operands LSB-first, one bit per clock,
//   under a Start/Busy/Done handshake. The result register keeps the last
//   completed value for display and acts as the accumulator for ACC.
//
// Ports
//   i_clk       system clock, rising edge active
//   i_rst_n     asynchronous active-low reset
//   i_start     operation request, sampled only while idle
//   i_op        00 ADD, 01 SUB, 10 ACC, 11 CLR (sampled with i_start)
//   i_a         first operand (ADD/SUB), addend (ACC)
//   i_b         second operand (ADD/SUB), ignored for ACC/CLR
//   i_cin       carry-in for ADD/ACC, ignored for SUB/CLR
//   o_busy      high while bits are being processed (exactly WIDTH cycles)
//   o_done      one-cycle completion pulse
//   o_result    result of the last completed operation
//   o_cout      carry out of the MSB (SUB: 1 = no borrow)
//   o_overflow  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ACC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_s;
    logic             r_carry;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_ovf;

    logic             w_sum;
    logic             w_carry;
    logic             w_last;
    logic [WIDTH-1:0] w_s_next;

    // The single full-adder cell.
    assign w_sum    = r_x[0] ^ r_y[0] ^ r_carry;
    assign w_carry  = (r_x[0] & r_y[0]) | (r_x[0] & r_carry) | (r_y[0] & r_carry);
    assign w_last   = (r_cnt == LAST_BIT);
    assign w_s_next = {w_sum, r_s[WIDTH-1:1]};

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    // CLR completes at the accept edge and skips RUN entirely.
                    w_next = (i_op == OP_CLR) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: operand load, bit-serial processing, result commit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_x      <= '0;
            r_y      <= '0;
            r_s      <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cnt <= '0;
                        r_s   <= '0;
                        case (i_op)
                            OP_ADD: begin
                                r_x     <= i_a;
                                r_y     <= i_b;
                                r_carry <= i_cin;
                            end
                            OP_SUB: begin
                                // Two's complement: A + ~B + 1.
                                r_x     <= i_a;
                                r_y     <= ~i_b;
                                r_carry <= 1'b1;
                            end
                            OP_ACC: begin
                                r_x     <= r_result;
                                r_y     <= i_a;
                                r_carry <= i_cin;
                            end
                            default: begin
                                r_result <= '0;
                                r_cout   <= 1'b0;
                                r_ovf    <= 1'b0;
                            end
                        endcase
                    end
                end
                S_RUN: begin
                    r_s     <= w_s_next;
                    r_x     <= r_x >> 1;
                    r_y     <= r_y >> 1;
                    r_carry <= w_carry;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        // On the MSB cycle r_carry is the carry into the MSB.
                        r_result <= w_s_next;
                        r_cout   <= w_carry;
                        r_ovf    <= r_carry ^ w_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == S_RUN);
    assign o_done     = (r_state == S_DONE);
    assign o_result   = r_result;
    assign o_cout     = r_cout;
    assign o_overflow = r_ovf;

endmodule
